amm_burst_master: RTL
=====================

// Module: amm_burst_master
// PURPOSE
//  Avalon-MM burst initiator driving the memory-side (mem) end of amm_if: writes a deterministic
//  pattern burst, or reads a burst back and checks it against the same pattern. Sits between the
//  checker control logic (one command at a time) and the memory under test.
// PARAMETERS
//  ADDR_W   32  address width (word address)
//  DATA_W   32  data width; multiple of 8
//  BURST_W  11  burstcount width; max burst = 2**(BURST_W-1)
// PORTS
//  clk            in   1              clock
//  srst_n         in   1              synchronous reset, active-low
//  cmd_valid      in   1              command request
//  cmd_ready      out  1              engine idle, command accepted when valid&ready
//  cmd_write      in   1              1 = write burst, 0 = read-and-check burst
//  cmd_addr       in   ADDR_W         burst start address
//  cmd_len        in   BURST_W        beats in burst, 0..2**(BURST_W-1)
//  cmd_seed       in   DATA_W         pattern seed
//  done           out  1              1-cycle pulse, command finished
//  err_cnt        out  32             mismatching read beats since reset (saturating)
//  amm_address    out  ADDR_W  | amm_read out 1 | amm_write out 1 | amm_burstcount out BURST_W
//  amm_writedata  out  DATA_W  | amm_byteenable out DATA_W/8 (all ones)
//  amm_readdata   in   DATA_W  | amm_readdatavalid in 1 | amm_waitrequest in 1
// BEHAVIOUR
//  - Reset (srst_n low on rising clk): state IDLE, cmd_ready=1, done=0, err_cnt=0, amm_read=0,
//    amm_write=0, address/burstcount/writedata=0, byteenable all ones. Reset mid-burst abandons it;
//    late readdatavalid after reset is ignored (state IDLE).
//  - Pattern: beat i of burst -> pat(i) = cmd_seed + ZEXT(cmd_addr) + i, modulo 2**DATA_W.
//  - FSM IDLE -> WR_BURST | RD_REQ -> RD_DATA -> IDLE. Command latched on valid&ready.
//  - cmd_len==0: no bus activity; done pulses the cycle after acceptance; back to IDLE.
//  - WR_BURST: amm_write=1 from the cycle after acceptance; address and burstcount held constant
//    for the whole burst; writedata=pat(beat); beat advances only when !amm_waitrequest; after last
//    accepted beat write drops, done pulses same cycle as return to IDLE (1 cycle after last beat).
//  - RD_REQ: amm_read=1 with address/burstcount held until cycle with !amm_waitrequest; then read=0.
//  - RD_DATA: each readdatavalid compares readdata to pat(rx_beat); mismatch increments err_cnt
//    (saturates at 32'hFFFF_FFFF); after final beat -> IDLE with done pulse next cycle.
//  - One outstanding transaction; cmd_ready=0 outside IDLE. readdatavalid in any other state ignored.
//  - read and write never asserted together; waitrequest stall may be arbitrarily long.
// CONFIGURATION
//  AMM_BURST_MASTER_ERR_LOG_EN defined: extra outputs err_addr (ADDR_W), err_exp, err_got (DATA_W),
//    err_vld (1); capture first mismatch since reset (address = burst base + beat); held until reset.
//  Undefined: those ports and capture registers absent; err_cnt only.
// STRUCTURE
//  - Package amm_burst_pkg: state enum (IDLE, WR_BURST, RD_REQ, RD_DATA), pattern function
//    pat(seed, addr, beat), MAX_BURST localparam derivation.
//  - Single module; beat counter + FSM inline. No sub-module required.
// TESTING
//  - Write, addr=0x100, len=4, seed=0, no waitrequest -> 4 write beats, data 0x100..0x103,
//    burstcount=4 constant, done 1 cycle after beat 4.
//  - Same write with waitrequest high 3 cycles on beat 2 -> signals frozen, still exactly 4 beats.
//  - Read back addr=0x100 len=4 seed=0, memory returns matching data with gaps -> err_cnt=0, done.
//  - Read with beat 3 corrupted to 0xDEAD -> err_cnt=1; with ERR_LOG_EN err_addr=0x102,
//    err_exp=0x102, err_got=0xDEAD.
//  - cmd_len=0 -> no read/write asserted, done 1 cycle after accept.
//  - srst_n low mid write burst -> next cycle write=0, cmd_ready=1; new command runs cleanly.

Source files
------------

// File: rtl/amm_burst_pkg.sv
// Shared types and helpers for the Avalon-MM burst pattern master.
package amm_burst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_REQ   = 2'd2,
    RD_DATA  = 2'd3
  } state_e;

  localparam int unsigned DEF_BURST_W = 11;

  function automatic int unsigned max_burst(input int unsigned burst_w);
    return 32'd1 << (burst_w - 1);
  endfunction

  localparam int unsigned MAX_BURST = max_burst(DEF_BURST_W);

  // Pattern arithmetic is carried at 64 bits; callers truncate to DATA_W (ADDR_W, DATA_W <= 64).
  localparam int unsigned PAT_W = 64;

  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                           input logic [PAT_W-1:0] addr,
                                           input logic [PAT_W-1:0] beat);
    return seed + addr + beat;
  endfunction

endpackage

// File: rtl/amm_burst_master_if.sv
// Avalon-MM burst bus between the pattern master and the memory under test.
interface amm_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = 11
);
  logic [ADDR_W-1:0]   amm_address;
  logic                amm_read;
  logic                amm_write;
  logic [BURST_W-1:0]  amm_burstcount;
  logic [DATA_W-1:0]   amm_writedata;
  logic [DATA_W/8-1:0] amm_byteenable;
  logic [DATA_W-1:0]   amm_readdata;
  logic                amm_readdatavalid;
  logic                amm_waitrequest;

  modport master (
    output amm_address, amm_read, amm_write, amm_burstcount, amm_writedata, amm_byteenable,
    input  amm_readdata, amm_readdatavalid, amm_waitrequest
  );

  modport slave (
    input  amm_address, amm_read, amm_write, amm_burstcount, amm_writedata, amm_byteenable,
    output amm_readdata, amm_readdatavalid, amm_waitrequest
  );
endinterface

// File: rtl/amm_burst_master.sv
// Avalon-MM burst initiator: writes a seed+address+beat pattern or reads a burst back and checks it.
// Optional first-mismatch capture ports enabled by AMM_BURST_MASTER_ERR_LOG_EN.
module amm_burst_master
  import amm_burst_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               srst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [DATA_W-1:0]  cmd_seed,
  output logic               done,
  output logic [31:0]        err_cnt,
  amm_if.master              amm
`ifdef AMM_BURST_MASTER_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [DATA_W-1:0]  err_exp,
  output logic [DATA_W-1:0]  err_got,
  output logic               err_vld
`endif
);

  state_e             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_len;
  logic [BURST_W-1:0] r_beat;
  logic [DATA_W-1:0]  r_seed;
  logic               r_done;
  logic [31:0]        r_err_cnt;

  logic               w_accept;
  logic               w_adv;
  logic               w_last;
  logic               w_mismatch;
  logic [DATA_W-1:0]  w_pat;

  assign w_accept   = (r_state == IDLE) && cmd_valid;
  assign w_last     = (r_beat == (r_len - BURST_W'(1)));
  assign w_pat      = DATA_W'(pat(PAT_W'(r_seed), PAT_W'(r_addr), PAT_W'(r_beat)));
  assign w_mismatch = (r_state == RD_DATA) && amm.amm_readdatavalid && (amm.amm_readdata != w_pat);

  always_ff @(posedge clk) begin
    if (!srst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && (cmd_len != '0)) w_next = cmd_write ? WR_BURST : RD_REQ;
      end
      WR_BURST: begin
        if (!amm.amm_waitrequest) begin
          w_adv = 1'b1;
          if (w_last) w_next = IDLE;
        end
      end
      RD_REQ: begin
        if (!amm.amm_waitrequest) w_next = RD_DATA;
      end
      RD_DATA: begin
        if (amm.amm_readdatavalid) begin
          w_adv = 1'b1;
          if (w_last) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_seed    <= '0;
      r_done    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_seed <= cmd_seed;
        r_beat <= '0;
        r_done <= (cmd_len == '0);
      end else if (w_adv) begin
        r_beat <= r_beat + BURST_W'(1);
        if (w_last) r_done <= 1'b1;
      end
      if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

`ifdef AMM_BURST_MASTER_ERR_LOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_exp;
  logic [DATA_W-1:0] r_err_got;
  logic              r_err_vld;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_err_addr <= '0;
      r_err_exp  <= '0;
      r_err_got  <= '0;
      r_err_vld  <= 1'b0;
    end else if (w_mismatch && !r_err_vld) begin
      r_err_addr <= r_addr + ADDR_W'(r_beat);
      r_err_exp  <= w_pat;
      r_err_got  <= amm.amm_readdata;
      r_err_vld  <= 1'b1;
    end
  end

  assign err_addr = r_err_addr;
  assign err_exp  = r_err_exp;
  assign err_got  = r_err_got;
  assign err_vld  = r_err_vld;
`endif

  assign cmd_ready = (r_state == IDLE);
  assign done      = r_done;
  assign err_cnt   = r_err_cnt;

  assign amm.amm_write      = (r_state == WR_BURST);
  assign amm.amm_read       = (r_state == RD_REQ);
  assign amm.amm_address    = (amm.amm_write || amm.amm_read) ? r_addr : '0;
  assign amm.amm_burstcount = (amm.amm_write || amm.amm_read) ? r_len  : '0;
  assign amm.amm_writedata  = amm.amm_write ? w_pat : '0;
  assign amm.amm_byteenable = '1;

endmodule
